// File: rtl/cnn_sequencer.sv
// Sequences one CNN job: weight load into FeatureMem, engine clear, NPIX enabled cycles, done pulse.
// All outputs registered; a write strobe follows its weight-set transfer by one cycle.
module cnn_sequencer #(
    parameter int IMAGE_WIDTH  = 28,
    parameter int IMAGE_HEIGHT = 28,
    parameter int NUM_FEATURES = 10,
    parameter int KERNEL_SIZE  = 3,
    parameter int STRIDE       = 1,
    localparam int WD     = 2 * KERNEL_SIZE * KERNEL_SIZE,
    localparam int OUT_W  = (IMAGE_WIDTH - KERNEL_SIZE) / STRIDE + 1,
    localparam int OUT_H  = (IMAGE_HEIGHT - KERNEL_SIZE) / STRIDE + 1,
    localparam int NPIX   = OUT_W * OUT_H,
    localparam int ADDR_W = $clog2(NUM_FEATURES) + 1,
    localparam int PIX_W  = $clog2(NPIX + 1)
) (
    input  logic              clk,
    input  logic              rst_cnn,
    input  logic              start,
    input  logic              abort,
    input  logic              wt_valid,
    input  logic [WD-1:0]     wt_data,
    output logic              wt_ready,
    output logic [ADDR_W-1:0] feature_writeAddr,
    output logic              feature_WrEn,
    output logic [WD-1:0]     weights_out,
    output logic              conv_clear_n,
    output logic              convolution_enable,
    output logic [PIX_W-1:0]  pix_count,
    output logic              busy,
    output logic              done
);

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_CLEAR, S_CONV, S_DONE} state_t;

    state_t              r_state, w_state;
    logic [ADDR_W-1:0]   r_idx, w_idx;
    logic                r_wt_ready, w_wt_ready;
    logic [ADDR_W-1:0]   r_addr, w_addr;
    logic                r_wren_n, w_wren_n;
    logic [WD-1:0]       r_wts, w_wts;
    logic                r_clr_n, w_clr_n;
    logic                r_en_n, w_en_n;
    logic [PIX_W-1:0]    r_pix, w_pix;
    logic                r_busy, w_busy;
    logic                r_done, w_done;
    logic                w_xfer;

    assign w_xfer = (r_state == S_LOAD) && r_wt_ready && wt_valid;

    // Outputs are computed for the coming cycle, so every strobe comes straight from a flop.
    always_comb begin
        w_state    = r_state;
        w_idx      = r_idx;
        w_wt_ready = 1'b0;
        w_addr     = r_addr;
        w_wren_n   = 1'b1;
        w_wts      = r_wts;
        w_clr_n    = 1'b1;
        w_en_n     = 1'b1;
        w_pix      = r_pix;
        w_done     = 1'b0;
        if (abort) begin
            w_state = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        w_state    = S_LOAD;
                        w_idx      = '0;
                        w_pix      = '0;
                        w_wt_ready = 1'b1;
                    end
                end
                S_LOAD: begin
                    w_wt_ready = 1'b1;
                    if (w_xfer) begin
                        w_wren_n = 1'b0;
                        w_addr   = r_idx;
                        w_wts    = wt_data;
                        w_idx    = r_idx + ADDR_W'(1);
                        if (r_idx == ADDR_W'(NUM_FEATURES - 1)) begin
                            w_wt_ready = 1'b0;
                            w_state    = S_CLEAR;
                        end
                    end
                end
                S_CLEAR: begin
                    w_clr_n = 1'b0;
                    w_state = S_CONV;
                end
                S_CONV: begin
                    if (r_pix <= PIX_W'(NPIX - 1)) begin
                        w_en_n = 1'b0;
                        w_pix  = r_pix + PIX_W'(1);
                    end else begin
                        w_done  = 1'b1;
                        w_state = S_DONE;
                    end
                end
                S_DONE: begin
                    w_state = S_IDLE;
                end
                default: w_state = S_IDLE;
            endcase
        end
        w_busy = (w_state != S_IDLE);
    end

    always_ff @(posedge clk or negedge rst_cnn) begin
        if (!rst_cnn) begin
            r_state    <= S_IDLE;
            r_idx      <= '0;
            r_wt_ready <= 1'b0;
            r_addr     <= '0;
            r_wren_n   <= 1'b1;
            r_wts      <= '0;
            r_clr_n    <= 1'b1;
            r_en_n     <= 1'b1;
            r_pix      <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_state    <= w_state;
            r_idx      <= w_idx;
            r_wt_ready <= w_wt_ready;
            r_addr     <= w_addr;
            r_wren_n   <= w_wren_n;
            r_wts      <= w_wts;
            r_clr_n    <= w_clr_n;
            r_en_n     <= w_en_n;
            r_pix      <= w_pix;
            r_busy     <= w_busy;
            r_done     <= w_done;
        end
    end

    assign wt_ready           = r_wt_ready;
    assign feature_writeAddr  = r_addr;
    assign feature_WrEn       = r_wren_n;
    assign weights_out        = r_wts;
    assign conv_clear_n       = r_clr_n;
    assign convolution_enable = r_en_n;
    assign pix_count          = r_pix;
    assign busy               = r_busy;
    assign done               = r_done;

endmodule

// File: doc/cnn_sequencer.md
Name: cnn_sequencer

Overview:
- Top-level controller for the single-layer CNN datapath: CNN core, FeatureMem and the KERNEL_SIZE²×NUM_FEATURES PE array.
- After a start pulse it streams NUM_FEATURES weight sets into feature memory through a valid/ready handshake, then clears the convolution engine.
- It holds the engine's active-low enable for exactly one full output map of cycles, then reports completion.
- External hosts deal only with handshakes and never drive active-low strobes directly.

Parameters:
- IMAGE_WIDTH, 28, input image width in pixels
- IMAGE_HEIGHT, 28, input image height in pixels
- NUM_FEATURES, 10, number of feature kernels to load
- KERNEL_SIZE, 3, kernel edge length; weights per feature = KERNEL_SIZE²
- STRIDE, 1, convolution stride; derived OUT_W=(IMAGE_WIDTH-KERNEL_SIZE)/STRIDE+1, OUT_H likewise, NPIX=OUT_W*OUT_H

Ports:
- clk  in  1  system clock; this block is posedge, the CNN core samples on negedge
- rst_cnn  in  1  reset, asynchronous, active-low
- start  in  1  begin a load+convolve job; sampled only in IDLE
- abort  in  1  synchronous job cancel, highest priority after reset
- wt_valid  in  1  host weight set valid
- wt_data  in  2*KERNEL_SIZE²  packed signed 2-bit weights, element 0 in LSBs
- wt_ready  out  1  sequencer accepts a weight set
- feature_writeAddr  out  $clog2(NUM_FEATURES)+1  FeatureMem write address
- feature_WrEn  out  1  FeatureMem write enable, active-low
- weights_out  out  2*KERNEL_SIZE²  registered copy of accepted wt_data
- conv_clear_n  out  1  clear to CNN core, active-low
- convolution_enable  out  1  CNN run enable, active-low
- pix_count  out  $clog2(NPIX+1)  enabled cycles issued in the current CONV phase
- busy  out  1  high in any state except IDLE
- done  out  1  one-cycle completion pulse

Behaviour:
- Reset (async, rst_cnn=0) puts the FSM in IDLE and sets every output to its reset value:
  - wt_ready=0, feature_writeAddr=0, feature_WrEn=1, weights_out=0
  - conv_clear_n=1, convolution_enable=1
  - pix_count=0, busy=0, done=0
- All outputs are registered. The FSM has states IDLE, LOAD, CLEAR, CONV, DONE.
- IDLE: start=1 → LOAD next cycle, with the feature index cleared to 0.
- LOAD, handshake:
  - wt_ready=1 throughout LOAD.
  - A transfer occurs on a posedge with wt_valid&wt_ready; one transfer per cycle is allowed (back-to-back).
- LOAD, write strobe:
  - The cycle after each transfer: feature_WrEn=0, feature_writeAddr=idx, weights_out=wt_data; idx increments.
  - feature_WrEn returns to 1 unless a further transfer occurred.
- LOAD exit:
  - The transfer with idx=NUM_FEATURES-1 drops wt_ready in the next cycle, together with that final write strobe, and moves to CLEAR.
  - wt_valid while not in LOAD is ignored.
- CLEAR: conv_clear_n=0 for exactly 1 cycle → CONV.
- CONV:
  - convolution_enable=0 for exactly NPIX consecutive cycles; pix_count increments each such cycle, saturating at NPIX.
  - After the NPIX-th cycle, convolution_enable=1 → DONE.
  - Each enabled cycle spans exactly one CNN negedge, so the core sees NPIX enabled samples.
- DONE: done=1 for 1 cycle → IDLE.
  - pix_count holds NPIX until the next start.
  - A start asserted in the DONE cycle is ignored.
- start outside IDLE is ignored; there is no queueing.
- abort=1 in any state:
  - Next cycle: IDLE, with wt_ready=0, feature_WrEn=1, conv_clear_n=1, convolution_enable=1.
  - done is not pulsed; pix_count holds its value.
  - A pending write strobe is cancelled.
- abort and start in the same IDLE cycle: abort wins and the FSM stays IDLE.
- Reset mid-job: immediate async return to the reset values; memory contents are not touched.
- Counter widths must not wrap:
  - idx compares against NUM_FEATURES-1.
  - pix_count compares against NPIX-1.

Test Plan:
- Reset then idle: hold rst_cnn=0, pulse clk → all outputs at reset values; release, 5 idle cycles → busy=0, feature_WrEn=1.
- Full job, back-to-back weights:
  - Stimulus: start, then wt_valid held high for 10 cycles with wt_data=idx pattern.
  - Required: 10 consecutive feature_WrEn=0 cycles with addr 0..9 and weights_out matching data.
  - Then 1 conv_clear_n=0 cycle, exactly 676 convolution_enable=0 cycles, pix_count=676, one done pulse, busy=0.
- Stalled host: wt_valid toggled 1/0 → 10 writes total with gaps, addr strictly 0..9 in order, CLEAR only after the 10th write strobe.
- Abort in CONV: abort at pix_count=300 → convolution_enable=1 next cycle, IDLE, no done pulse, pix_count=300; a following start runs a full 676-cycle job.
- Ignored inputs:
  - start pulsed during LOAD and CONV → no effect on idx or pix_count.
  - wt_valid in IDLE → no feature_WrEn strobe.
- Async reset in LOAD after 4 writes → outputs at reset values at once, with no further strobes; new start reloads from addr 0.
